// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Cleans up the five raw push-buttons of the timer/VGA board. Each button is
// synchronised into clk, debounced, and turned into a held level plus a
// single-cycle press pulse. Up and down additionally auto-repeat while held,
// so the timer can ramp its setting with a direction key.
//
// Ports:
//   clk          - system clock
//   reset        - asynchronous, active-high; clears all state
//   upButton     - raw up button (asynchronous, active-high)
//   downButton   - raw down button
//   leftButton   - raw left button
//   rightButton  - raw right button
//   actionButton - raw centre button
//   btn_level    - debounced held level, [0]=up [1]=down [2]=left [3]=right
//                  [4]=action
//   btn_pulse    - one-cycle press or auto-repeat pulse, same bit order
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       upButton,
  input  logic       downButton,
  input  logic       leftButton,
  input  logic       rightButton,
  input  logic       actionButton,
  output logic [4:0] btn_level,
  output logic [4:0] btn_pulse
);

  // Counters stop at "value - 1" and clear, so they never wrap.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  logic [4:0]            raw;
  logic [4:0]            sync_p0_q;
  logic [4:0]            sync_p1_q;

  logic [4:0][CNT_W-1:0] db_cnt_q;
  logic [4:0][CNT_W-1:0] db_cnt_d;
  logic [4:0]            level_q;
  logic [4:0]            level_d;
  logic [4:0]            rise;
  logic [1:0]            fall_ud;

  rpt_state_t            state_q;
  rpt_state_t            state_d;
  logic                  held_q;
  logic                  held_d;
  logic [CNT_W-1:0]      rcnt_q;
  logic [CNT_W-1:0]      rcnt_d;
  logic [CNT_W-1:0]      rcnt_last;
  logic [1:0]            rep;

  logic [4:0]            pulse_q;
  logic [4:0]            pulse_d;

  assign raw = {actionButton, rightButton, leftButton, downButton, upButton};

  // ---- stage p0/p1: two-flop synchroniser ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0_q <= '0;
      sync_p1_q <= '0;
    end else begin
      sync_p0_q <= raw;
      sync_p1_q <= sync_p0_q;
    end
  end

  // ---- debounce: count consecutive mismatches, flip on the last one ----
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    for (int i = 0; i < 5; i++) begin
      if (sync_p1_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edges are taken on the next level so pulses line up with the level change.
  assign rise    = level_d & ~level_q;
  assign fall_ud = level_q[1:0] & ~level_d[1:0];

  // ---- auto-repeat FSM shared by up and down ----
  assign rcnt_last = (state_q == RPT_DELAY) ? RD_LAST : RR_LAST;

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    rcnt_d  = rcnt_q;
    rep     = '0;
    case (state_q)
      RPT_IDLE: begin
        rcnt_d = '0;
        // Start only when the rising key is the sole direction key held;
        // releasing one of two held keys never restarts the repeat.
        if (rise[0] && !level_d[1]) begin
          state_d = RPT_DELAY;
          held_d  = 1'b0;
        end else if (rise[1] && !level_d[0]) begin
          state_d = RPT_DELAY;
          held_d  = 1'b1;
        end
      end
      RPT_DELAY, RPT_REPEAT: begin
        // Abort takes priority, which also suppresses a repeat pulse that
        // would coincide with the release.
        if ((|fall_ud) || (&level_d[1:0])) begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == rcnt_last) begin
          rep[held_q] = 1'b1;
          state_d     = RPT_REPEAT;
          rcnt_d      = '0;
        end else begin
          rcnt_d = rcnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RPT_IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  assign pulse_d = rise | {3'b000, rep};

  // ---- stage p2: debounced level, repeat state and registered pulses ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q <= '0;
      level_q  <= '0;
      state_q  <= RPT_IDLE;
      held_q   <= 1'b0;
      rcnt_q   <= '0;
      pulse_q  <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      state_q  <= state_d;
      held_q   <= held_d;
      rcnt_q   <= rcnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_RATE=3. A behavioural model (sliding window of synchronised samples
// for debounce, press-time arithmetic for auto-repeat) predicts outputs each
// cycle; directed scenarios also check hand-derived cycle numbers.
// Cycle k is the interval after edge k; inputs change 1 time unit after an
// edge and outputs are sampled 1 time unit after an edge.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic       clk;
  logic       reset;
  logic       up_b, down_b, left_b, right_b, action_b;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;

  int errors;
  int checks;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .upButton    (up_b),
    .downButton  (down_b),
    .leftButton  (left_b),
    .rightButton (right_b),
    .actionButton(action_b),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [4:0] mr1, mr2;
  logic [4:0] mlvl, mpulse;
  bit         win [5][$];
  int         mcyc;
  bit         m_rpt_on;
  int         m_press;
  int         m_rpt_btn;

  task model_reset;
    mr1      = '0;
    mr2      = '0;
    mlvl     = '0;
    mpulse   = '0;
    m_rpt_on = 1'b0;
    for (int i = 0; i < 5; i++) win[i].delete();
  endtask

  task model_update;
    logic [4:0] d;
    logic [4:0] old;
    bit         all_diff;
    // The debouncer sees the raw value sampled two edges earlier.
    d    = mr2;
    mr2  = mr1;
    mr1  = {action_b, right_b, left_b, down_b, up_b};
    old  = mlvl;
    mcyc = mcyc + 1;
    for (int i = 0; i < 5; i++) begin
      win[i].push_back(d[i]);
      if (win[i].size() > DB) void'(win[i].pop_front());
      all_diff = (win[i].size() == DB);
      for (int j = 0; j < win[i].size(); j++)
        if (win[i][j] == old[i]) all_diff = 1'b0;
      if (all_diff) mlvl[i] = ~old[i];
    end
    mpulse = mlvl & ~old;
    if (m_rpt_on) begin
      if (((old[1:0] & ~mlvl[1:0]) != 2'b00) || (mlvl[1:0] == 2'b11))
        m_rpt_on = 1'b0;
      else if ((mcyc - m_press >= RD) && ((mcyc - m_press - RD) % RR == 0))
        mpulse[m_rpt_btn] = 1'b1;
    end else begin
      if (mpulse[0] && !mlvl[1]) begin
        m_rpt_on = 1'b1; m_press = mcyc; m_rpt_btn = 0;
      end else if (mpulse[1] && !mlvl[0]) begin
        m_rpt_on = 1'b1; m_press = mcyc; m_rpt_btn = 1;
      end
    end
  endtask

  task step;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (btn_level !== 5'b0 || btn_pulse !== 5'b0) begin
      errors++;
      $display("FAIL reset_assert level=%b pulse=%b expected 00000/00000", btn_level, btn_pulse);
    end
    model_reset();
    {action_b, right_b, left_b, down_b, up_b} = 5'b11111;
    repeat (8) begin
      @(posedge clk); #1;
      checks++;
      if (btn_level !== 5'b0 || btn_pulse !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold level=%b pulse=%b expected 00000/00000", btn_level, btn_pulse);
      end
    end
    {action_b, right_b, left_b, down_b, up_b} = 5'b00000;
    #3 reset = 1'b0;
    repeat (10) begin
      step();
      checks++;
      if (btn_level !== 5'b0 || btn_pulse !== 5'b0) begin
        errors++;
        $display("FAIL reset_idle level=%b pulse=%b expected 00000/00000", btn_level, btn_pulse);
      end
    end
  endtask

  task automatic test_clean_press;
    int e; logic exp_l, exp_p;
    for (int k = 0; k < 60; k++) begin
      left_b = (k >= 10 && k < 40);
      step(); e = k + 1;
      exp_l = (e >= 16 && e < 46);
      exp_p = (e == 16);
      checks++;
      if (btn_level !== mlvl || btn_pulse !== mpulse) begin
        errors++;
        $display("FAIL clean_press_model e=%0d level=%b/%b pulse=%b/%b", e, btn_level, mlvl, btn_pulse, mpulse);
      end
      checks++;
      if (btn_level[2] !== exp_l || btn_pulse[2] !== exp_p) begin
        errors++;
        $display("FAIL clean_press e=%0d level2=%b exp %b pulse2=%b exp %b", e, btn_level[2], exp_l, btn_pulse[2], exp_p);
      end
    end
  endtask

  task automatic test_bounce;
    int e, npulse; logic exp_l, exp_p;
    npulse = 0;
    for (int k = 0; k < 60; k++) begin
      if (k < 20) action_b = ((k / 2) % 2 == 0);
      else        action_b = (k < 40);
      step(); e = k + 1;
      if (btn_pulse[4]) npulse++;
      exp_l = (e >= 26 && e < 46);
      exp_p = (e == 26);
      checks++;
      if (btn_level !== mlvl || btn_pulse !== mpulse) begin
        errors++;
        $display("FAIL bounce_model e=%0d level=%b/%b pulse=%b/%b", e, btn_level, mlvl, btn_pulse, mpulse);
      end
      checks++;
      if (btn_level[4] !== exp_l || btn_pulse[4] !== exp_p) begin
        errors++;
        $display("FAIL bounce e=%0d level4=%b exp %b pulse4=%b exp %b", e, btn_level[4], exp_l, btn_pulse[4], exp_p);
      end
    end
    checks++;
    if (npulse != 1) begin
      errors++;
      $display("FAIL bounce_count pulses=%0d expected 1", npulse);
    end
  endtask

  task automatic test_auto_repeat;
    int e; logic exp_l, exp_p;
    for (int k = 0; k < 62; k++) begin
      up_b = (k < 40);
      step(); e = k + 1;
      exp_l = (e >= 6 && e < 46);
      exp_p = (e == 6) || (e >= 16 && e <= 43 && (e - 16) % 3 == 0);
      checks++;
      if (btn_level !== mlvl || btn_pulse !== mpulse) begin
        errors++;
        $display("FAIL auto_repeat_model e=%0d level=%b/%b pulse=%b/%b", e, btn_level, mlvl, btn_pulse, mpulse);
      end
      checks++;
      if (btn_level[0] !== exp_l || btn_pulse[0] !== exp_p) begin
        errors++;
        $display("FAIL auto_repeat e=%0d level0=%b exp %b pulse0=%b exp %b", e, btn_level[0], exp_l, btn_pulse[0], exp_p);
      end
    end
  endtask

  task automatic test_up_down;
    int e; logic exp_p0, exp_p1;
    for (int k = 0; k < 72; k++) begin
      up_b   = (k < 50);
      down_b = (k >= 20 && k < 40);
      step(); e = k + 1;
      exp_p0 = (e == 6) || (e == 16) || (e == 19) || (e == 22) || (e == 25);
      exp_p1 = (e == 26);
      checks++;
      if (btn_level !== mlvl || btn_pulse !== mpulse) begin
        errors++;
        $display("FAIL up_down_model e=%0d level=%b/%b pulse=%b/%b", e, btn_level, mlvl, btn_pulse, mpulse);
      end
      checks++;
      if (btn_pulse[0] !== exp_p0 || btn_pulse[1] !== exp_p1) begin
        errors++;
        $display("FAIL up_down e=%0d pulse0=%b exp %b pulse1=%b exp %b", e, btn_pulse[0], exp_p0, btn_pulse[1], exp_p1);
      end
    end
  endtask

  task automatic test_reset_mid_repeat;
    int k, e; logic exp_l, exp_p;
    k = 0;
    while (k < 78) begin
      up_b = (k < 55);
      if (k == 25) begin
        #3 reset = 1'b1;
        #1;
        checks++;
        if (btn_level !== 5'b0 || btn_pulse !== 5'b0) begin
          errors++;
          $display("FAIL reset_mid_repeat_async level=%b pulse=%b expected 00000/00000", btn_level, btn_pulse);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #4 reset = 1'b0;
        k = 27;
      end
      step(); e = k + 1;
      if (e <= 25) begin
        exp_l = (e >= 6);
        exp_p = (e == 6) || (e >= 16 && (e - 16) % 3 == 0);
      end else begin
        exp_l = (e >= 33 && e < 61);
        exp_p = (e == 33) || (e >= 43 && e <= 58 && (e - 43) % 3 == 0);
      end
      checks++;
      if (btn_level !== mlvl || btn_pulse !== mpulse) begin
        errors++;
        $display("FAIL reset_mid_repeat_model e=%0d level=%b/%b pulse=%b/%b", e, btn_level, mlvl, btn_pulse, mpulse);
      end
      checks++;
      if (btn_level[0] !== exp_l || btn_pulse[0] !== exp_p) begin
        errors++;
        $display("FAIL reset_mid_repeat e=%0d level0=%b exp %b pulse0=%b exp %b", e, btn_level[0], exp_l, btn_pulse[0], exp_p);
      end
      k++;
    end
  endtask

  task automatic test_glitch;
    int e;
    for (int k = 0; k < 30; k++) begin
      right_b = (k >= 10 && k < 13);
      step(); e = k + 1;
      checks++;
      if (btn_level !== 5'b0 || btn_pulse !== 5'b0) begin
        errors++;
        $display("FAIL glitch e=%0d level=%b pulse=%b expected 00000/00000", e, btn_level, btn_pulse);
      end
    end
  endtask

  task automatic test_random;
    int         seg [5];
    logic [4:0] v;
    logic [4:0] prev_pulse;
    for (int i = 0; i < 5; i++) seg[i] = 0;
    v          = '0;
    prev_pulse = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 5; i++) begin
        if (seg[i] == 0) begin
          v[i]   = 1'($urandom_range(0, 1));
          seg[i] = (i < 2) ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 9));
        end
        seg[i]--;
      end
      if (k >= 2980) v = '0;
      {action_b, right_b, left_b, down_b, up_b} = v;
      step();
      checks++;
      if (btn_level !== mlvl || btn_pulse !== mpulse) begin
        errors++;
        $display("FAIL random_model k=%0d level=%b/%b pulse=%b/%b", k, btn_level, mlvl, btn_pulse, mpulse);
      end
      checks++;
      if ((btn_pulse & prev_pulse) !== 5'b0) begin
        errors++;
        $display("FAIL random_pulse_width k=%0d pulse=%b previous=%b", k, btn_pulse, prev_pulse);
      end
      prev_pulse = btn_pulse;
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    mcyc     = 0;
    m_press  = 0;
    m_rpt_btn = 0;
    reset    = 1'b0;
    {action_b, right_b, left_b, down_b, up_b} = 5'b00000;
    model_reset();

    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_up_down();
    test_reset_mid_repeat();
    test_glitch();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
